// File: rtl/pipe_skid_if.sv
// Handshake bundle for one elastic pipeline stage boundary.
interface pipe_skid_if #(
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned DATA_W = 97,
  parameter int unsigned REG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [REG_W-1:0]  in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [REG_W-1:0]  out_dest;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_dest;
  logic [1:0]        occupancy;

  // Producer/consumer side that drives the stage and observes it.
  modport master (
    output flush, in_valid, in_ctrl, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_dest,
           fwd_valid, fwd_dest, occupancy
  );

  // The stage register itself.
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_dest,
           fwd_valid, fwd_dest, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a forwarding tap for the hazard unit.
module pipe_skid_reg #(
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned DATA_W = 97,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned SKID   = 1
) (
  input  logic clk,
  input  logic reset,
  pipe_skid_if.slave bus
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              head_valid_q, head_valid_d;
  logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;
  logic [DATA_W-1:0] head_data_q,  head_data_d;
  logic [REG_W-1:0]  head_dest_q,  head_dest_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [REG_W-1:0]  skid_dest_q,  skid_dest_d;

  logic accept_c;
  logic release_c;

  // With a skid entry in_ready comes straight from a register; without one it
  // must look at out_ready to keep full throughput.
  assign bus.in_ready = HAS_SKID ? !skid_valid_q : (!head_valid_q || bus.out_ready);
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign release_c    = head_valid_q && bus.out_ready;

  // Head drives the outputs; ctrl is gated so a bubble never writes anything.
  assign bus.out_valid = head_valid_q;
  assign bus.out_ctrl  = head_valid_q ? head_ctrl_q : '0;
  assign bus.out_data  = head_data_q;
  assign bus.out_dest  = head_dest_q;
  assign bus.fwd_valid = head_valid_q && head_ctrl_q[0];
  assign bus.fwd_dest  = head_dest_q;
  assign bus.occupancy = 2'({1'b0, head_valid_q}) + 2'({1'b0, skid_valid_q});

  // Next-state: flush first, then refill head from skid or input, else park in skid.
  always_comb begin
    head_valid_d = head_valid_q;
    head_ctrl_d  = head_ctrl_q;
    head_data_d  = head_data_q;
    head_dest_d  = head_dest_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_dest_d  = skid_dest_q;

    if (bus.flush) begin
      head_valid_d = 1'b0;
      head_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (!head_valid_q || release_c) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_ctrl_d  = skid_ctrl_q;
        head_data_d  = skid_data_q;
        head_dest_d  = skid_dest_q;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        head_valid_d = 1'b1;
        head_ctrl_d  = bus.in_ctrl;
        head_data_d  = bus.in_data;
        head_dest_d  = bus.in_dest;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (HAS_SKID && accept_c) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = bus.in_ctrl;
      skid_data_d  = bus.in_data;
      skid_dest_d  = bus.in_dest;
    end
  end

  // Entry registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_valid_q <= 1'b0;
      head_ctrl_q  <= '0;
      head_data_q  <= '0;
      head_dest_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_dest_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_ctrl_q  <= head_ctrl_d;
      head_data_q  <= head_data_d;
      head_dest_q  <= head_dest_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_dest_q  <= skid_dest_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: one SKID=1 and one SKID=0 instance share stimulus.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_ctrl = 5'h00;
  logic [96:0] in_data = '0;
  logic [4:0]  in_dest = 5'h00;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_skid_if #(.CTRL_W(5), .DATA_W(97), .REG_W(5)) b1 ();
  pipe_skid_if #(.CTRL_W(5), .DATA_W(97), .REG_W(5)) b0 ();

  assign b1.flush = flush;      assign b0.flush = flush;
  assign b1.in_valid = in_valid; assign b0.in_valid = in_valid;
  assign b1.in_ctrl = in_ctrl;  assign b0.in_ctrl = in_ctrl;
  assign b1.in_data = in_data;  assign b0.in_data = in_data;
  assign b1.in_dest = in_dest;  assign b0.in_dest = in_dest;
  assign b1.out_ready = out_ready; assign b0.out_ready = out_ready;

  pipe_skid_reg #(.CTRL_W(5), .DATA_W(97), .REG_W(5), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  pipe_skid_reg #(.CTRL_W(5), .DATA_W(97), .REG_W(5), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stimulus cycle: drive, check in_ready before the edge, check outputs after.
  task automatic row(input bit skid, input logic v, input logic [7:0] d, input logic ordy,
                     input logic pre, input logic ov, input logic [7:0] od, input logic [1:0] occ);
    in_valid  = v;
    in_data   = 97'(d);
    out_ready = ordy;
    #1;
    check(skid ? "s1_pre_in_ready" : "s0_pre_in_ready", skid ? b1.in_ready : b0.in_ready, pre);
    tick();
    check(skid ? "s1_out_valid" : "s0_out_valid", skid ? b1.out_valid : b0.out_valid, ov);
    if (ov)
      check(skid ? "s1_out_data" : "s0_out_data", skid ? b1.out_data : b0.out_data, od);
    check(skid ? "s1_occupancy" : "s0_occupancy", skid ? b1.occupancy : b0.occupancy, occ);
  endtask

  initial begin
    // Reset state while reset is held
    #2;
    check("rst_in_ready1", b1.in_ready, 1);
    check("rst_in_ready0", b0.in_ready, 1);
    check("rst_out_valid", b1.out_valid, 0);
    check("rst_out_data", b1.out_data, 0);
    check("rst_out_ctrl", b1.out_ctrl, 0);
    check("rst_fwd", b1.fwd_valid, 0);
    check("rst_fwd_dest", b1.fwd_dest, 0);
    check("rst_occ", b1.occupancy, 0);
    #10 reset = 1'b1;

    // Full-rate stream with out_ready high, both variants
    in_ctrl   = 5'h1F;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 97'(i);
      in_dest = 5'(i);
      tick();
      check("str_out_data1", b1.out_data, i);
      check("str_out_valid1", b1.out_valid, 1);
      check("str_occ1", b1.occupancy, 1);
      check("str_in_ready1", b1.in_ready, 1);
      check("str_out_data0", b0.out_data, i);
      check("str_occ0", b0.occupancy, 1);
    end
    check("str_fwd", b1.fwd_valid, 1);
    in_valid = 1'b0;
    tick();
    check("str_drain", b1.out_valid, 0);
    check("str_drain_occ", b1.occupancy, 0);

    // SKID=1 back-pressure: three stall edges, one extra beat absorbed
    row(1, 1, 8'hA0, 1, 1, 1, 8'hA0, 1);
    row(1, 1, 8'hA1, 0, 1, 1, 8'hA0, 2);
    row(1, 1, 8'hA2, 0, 0, 1, 8'hA0, 2);
    row(1, 1, 8'hA2, 0, 0, 1, 8'hA0, 2);
    row(1, 1, 8'hA2, 1, 0, 1, 8'hA1, 1);
    row(1, 1, 8'hA2, 1, 1, 1, 8'hA2, 1);
    row(1, 1, 8'hA3, 1, 1, 1, 8'hA3, 1);
    row(1, 0, 8'hA3, 1, 1, 0, 8'hA3, 0);

    // SKID=0 stall: in_ready follows out_ready, never more than one entry
    row(0, 1, 8'hA0, 1, 1, 1, 8'hA0, 1);
    row(0, 1, 8'hA1, 0, 0, 1, 8'hA0, 1);
    row(0, 1, 8'hA1, 0, 0, 1, 8'hA0, 1);
    row(0, 1, 8'hA1, 0, 0, 1, 8'hA0, 1);
    row(0, 1, 8'hA1, 1, 1, 1, 8'hA1, 1);
    row(0, 1, 8'hA2, 1, 1, 1, 8'hA2, 1);
    row(0, 0, 8'hA2, 1, 1, 0, 8'hA2, 0);

    // Flush with both entries full; offered beat 0x55 is dropped
    row(1, 1, 8'hB0, 0, 1, 1, 8'hB0, 1);
    row(1, 1, 8'hB1, 0, 1, 1, 8'hB0, 2);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 97'h55;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", b1.out_valid, 0);
    check("fl_out_ctrl", b1.out_ctrl, 0);
    check("fl_fwd", b1.fwd_valid, 0);
    check("fl_occ", b1.occupancy, 0);
    check("fl_in_ready", b1.in_ready, 1);
    tick();
    check("fl_no_55", b1.out_valid, 0);
    check("fl_occ2", b1.occupancy, 0);

    // Forwarding tap and ctrl gating
    in_valid  = 1'b1;
    in_ctrl   = 5'h01;
    in_dest   = 5'd9;
    in_data   = 97'h9;
    out_ready = 1'b0;
    tick();
    check("fwd_valid_on", b1.fwd_valid, 1);
    check("fwd_dest", b1.fwd_dest, 9);
    check("fwd_out_dest", b1.out_dest, 9);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    in_ctrl  = 5'h1E;
    tick();
    check("fwd_valid_off", b1.fwd_valid, 0);
    check("fwd_ctrl", b1.out_ctrl, 5'h1E);
    in_valid = 1'b0;
    tick();
    check("gate_ctrl", b1.out_ctrl, 0);
    check("gate_valid", b1.out_valid, 0);

    // Asynchronous reset with two entries held
    in_ctrl = 5'h1F;
    row(1, 1, 8'hC0, 0, 1, 1, 8'hC0, 1);
    row(1, 1, 8'hC1, 0, 1, 1, 8'hC0, 2);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("ar_out_valid", b1.out_valid, 0);
    check("ar_out_data", b1.out_data, 0);
    check("ar_out_ctrl", b1.out_ctrl, 0);
    check("ar_out_dest", b1.out_dest, 0);
    check("ar_fwd", b1.fwd_valid, 0);
    check("ar_fwd_dest", b1.fwd_dest, 0);
    check("ar_occ", b1.occupancy, 0);
    check("ar_in_ready", b1.in_ready, 1);
    check("ar_occ0", b0.occupancy, 0);
    #10 reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register that generalises the fixed EX/MEM latch of the five-stage MIPS core into a reusable stage boundary for ID/EX, EX/MEM and MEM/WB. It carries a control bundle, a data payload and a destination-register index. It adds a valid/ready handshake, an optional two-entry skid buffer for full throughput under back-pressure, a synchronous flush for bubble injection on branch resolution, and a forwarding tap for the hazard unit.

## Interface
- CTRL_W, 5: width of control bundle (regWrite, memToReg, branch, memRead, memWrite, ...)
- DATA_W, 97: payload width (e.g. branch target + zero + ALU result + store data)
- REG_W, 5: destination register index width
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low
- flush  input  1  synchronous; invalidates all held entries
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream payload
- in_dest  input  REG_W  upstream destination register
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_ctrl  output  CTRL_W  head control; forced to 0 when out_valid=0
- out_data  output  DATA_W  head payload
- out_dest  output  REG_W  head destination register
- fwd_valid  output  1  out_valid AND out_ctrl[0] (regWrite)
- fwd_dest  output  REG_W  equals out_dest
- occupancy  output  2  number of valid entries, 0..2

## Operation
- Storage is a head entry (drives out_*) and, when SKID=1, a skid entry. Each entry holds a valid bit plus ctrl/data/dest.
- Accept: in_valid && in_ready. Release: out_valid && out_ready.
- SKID=1: in_ready = !skid_valid, taken from a register and never derived from out_ready.
  - Head empty, or head released: the accepted beat (or the skid contents if skid is valid) moves into the head.
  - Head held, skid empty, accept: the beat is written to skid.
  - Release with skid valid: skid moves to head and skid clears. A simultaneous accept is impossible because in_ready=0.
- SKID=0: in_ready = !out_valid || out_ready. The skid entry is absent and occupancy never exceeds 1.
- Order is strictly FIFO. No beat is lost or duplicated.
- Flush takes priority over accept and release in the same cycle. Both entries' valid bits clear, and their stored ctrl clears to 0. A beat offered in the flush cycle is dropped. Data and dest hold their old values; they are don't-care while invalid.
- out_ctrl gating guarantees that an invalid entry never asserts regWrite or memWrite downstream.
- occupancy = head_valid + skid_valid, from registers.

## Timing
- Reset (asynchronous assert, synchronous use after release):
  - all valid bits = 0 and all stored ctrl/data/dest = 0
  - outputs: out_valid=0, out_ctrl=0, out_data=0, out_dest=0, fwd_valid=0, fwd_dest=0, occupancy=0
  - in_ready=1 while reset is asserted and after release
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N and stays stable until released.
- Throughput is 1 beat/cycle with out_ready held high, for both SKID settings.
- SKID=1: after one cycle of out_ready=0 with a continuous input stream, in_ready drops on the following cycle. Exactly one extra beat is absorbed.
- Asserting reset mid-transfer discards all entries immediately; it does not wait for a clock edge.
- Flush takes effect at the edge it is sampled. out_valid=0 in the next cycle. in_ready=1 in the next cycle when SKID=1.

## Test plan
- Reset then stream: release reset, drive in_valid=1 with ctrl=5'h1F, data=1..8 on consecutive cycles, out_ready=1 -> out_data=1..8 each one cycle later, occupancy=1 throughout, no gaps.
- Back-pressure (SKID=1): stream data 0xA0.., drop out_ready for 3 cycles -> occupancy reaches 2, in_ready=0 for exactly those stall cycles plus none extra, all beats delivered in order.
- SKID=0 stall: same stimulus -> in_ready follows out_ready combinationally, occupancy ≤ 1, order preserved.
- Flush with full buffer: occupancy=2, assert flush with in_valid=1 (data 0x55) -> next cycle out_valid=0, out_ctrl=0, fwd_valid=0, occupancy=0; beat 0x55 never appears.
- Forwarding tap: head ctrl[0]=1 with dest=5'd9 -> fwd_valid=1, fwd_dest=9; with ctrl[0]=0 -> fwd_valid=0.
- Async reset mid-stream: assert reset between clock edges with occupancy=2 -> all outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
